// File: rtl/dmem_pkg.sv
// Shared encodings and defaults for the data-memory sequencer.
package dmem_pkg;

    // Access size encodings carried on the size port (2'b11 is illegal).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Default memory map: byte address of RAM word 0 and RAM depth in words.
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
    localparam int          DEF_DEPTH     = 1024;

    // IDLE: waiting for a request
    // ACC:  RAM access cycle (word write, or read issue)
    // CAP:  RAM read data is valid and is captured
    // WR:   write-back of the merged word of a partial store
    // RPT:  cycle in which a rejected access is reported
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RPT  = 3'd4
    } state_t;

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: load extraction/extension and partial-store merge.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] word,      // raw RAM word
    input  logic [31:0] wdata,     // right-aligned store data
    input  logic [1:0]  offset,    // byte offset within the word (little-endian)
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] ext,       // extracted and extended load value
    output logic [31:0] merged     // word with the addressed lane replaced
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane and extend it to 32 bits; words pass through.
    always_comb begin
        byte_v = word[{offset, 3'b000} +: 8];
        half_v = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: ext = {{24{sign_ext & byte_v[7]}}, byte_v};
            SZ_HALF: ext = {{16{sign_ext & half_v[15]}}, half_v};
            default: ext = word;
        endcase
    end

    // Replace only the addressed byte/half of the old word with the store data.
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer in front of a word-organised RAM with 1-cycle read.
// Handshake: req is sampled on a rising edge only while busy=0; the CPU holds
// req (and its operands) until done. done is a one-cycle registered pulse with
// err/rdata valid alongside it; busy is already low in the done cycle, so a
// request presented then is accepted on that cycle's closing edge.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          DEPTH     = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        ram_ena,
    output logic        ram_wena,
    output logic        ram_rena,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    // Size of the mapped window in bytes, wide enough never to overflow.
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    state_t      state, state_nx;
    logic        l_we, l_sext;
    logic [1:0]  l_size;
    logic [31:0] l_addr, l_wdata, merged_q;
    logic [31:0] ext_word, merged_word;
    logic [32:0] off33;
    logic        range_ok, req_err, word_store, accepting;

    // Rejection check on the incoming request; the 33-bit difference keeps
    // addresses below BASE_ADDR from wrapping into the window.
    always_comb begin
        off33    = {1'b0, addr} - {1'b0, BASE_ADDR};
        range_ok = (off33 < SPAN);
        req_err  = (size == 2'b11)
                 || ((size == SZ_HALF) && addr[0])
                 || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
                 || !range_ok;
    end

    assign word_store = l_we && (l_size == SZ_WORD);
    assign accepting  = (state == IDLE) || (state == RPT);
    assign busy       = !accepting;
    assign ram_addr   = (state == IDLE) ? 32'd0 : ((l_addr - BASE_ADDR) >> 2);

    dmem_lane u_lane (
        .word     (ram_rdata),
        .wdata    (l_wdata),
        .offset   (l_addr[1:0]),
        .size     (l_size),
        .sign_ext (l_sext),
        .ext      (ext_word),
        .merged   (merged_word)
    );

    // Next-state and RAM control decode; RAM controls depend only on state.
    always_comb begin
        state_nx  = state;
        ram_ena   = 1'b0;
        ram_wena  = 1'b0;
        ram_rena  = 1'b0;
        ram_wdata = 32'd0;
        case (state)
            IDLE, RPT: begin
                if (req) state_nx = req_err ? RPT : ACC;
                else     state_nx = IDLE;
            end
            ACC: begin
                ram_ena = 1'b1;
                if (word_store) begin
                    ram_wena  = 1'b1;
                    ram_wdata = l_wdata;
                    state_nx  = IDLE;
                end else begin
                    ram_rena = 1'b1;
                    state_nx = CAP;
                end
            end
            CAP: state_nx = l_we ? WR : IDLE;
            WR: begin
                ram_ena   = 1'b1;
                ram_wena  = 1'b1;
                ram_wdata = merged_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, request latch, completion flags and captured load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'd0;
            l_we     <= 1'b0;
            l_sext   <= 1'b0;
            l_size   <= 2'b00;
            l_addr   <= 32'd0;
            l_wdata  <= 32'd0;
            merged_q <= 32'd0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE, RPT: begin
                    if (req) begin
                        l_we    <= we;
                        l_size  <= size;
                        l_sext  <= sign_ext;
                        l_addr  <= addr;
                        l_wdata <= wdata;
                        // A rejected access completes in the following (RPT) cycle.
                        if (req_err) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (word_store) begin
                        done <= 1'b1;
                        err  <= 1'b0;
                    end
                end
                CAP: begin
                    if (l_we) begin
                        merged_q <= merged_word;
                    end else begin
                        rdata <= ext_word;
                        done  <= 1'b1;
                        err   <= 1'b0;
                    end
                end
                WR: begin
                    done <= 1'b1;
                    err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: behavioural RAM, request driver, and a done-driven
// monitor that pops expected {check_rdata, err, latency, rdata} entries.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [1:0]  SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

    logic        clk, rst, req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        ram_ena, ram_wena, ram_rena;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // expected entry: [37] check rdata, [36] err, [35:32] latency, [31:0] rdata
    logic [37:0] exp_q[$];
    int          acc_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM model ----------------
    logic [31:0] mem [0:1023];
    logic [31:0] ram_q;
    logic        ram_q_vld;
    logic        mem_clr;
    int          ena_cnt = 0;
    int          wr_cnt  = 0;
    logic [31:0] last_waddr = 32'hFFFF_FFFF;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
            ram_q_vld <= 1'b0;
            ram_q     <= 32'd0;
        end else begin
            ram_q_vld <= ram_ena && ram_rena;
            if (ram_ena) ena_cnt <= ena_cnt + 1;
            if (ram_ena && ram_wena) begin
                mem[ram_addr[9:0]] <= ram_wdata;
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= ram_addr;
            end
            if (ram_ena && ram_rena) ram_q <= mem[ram_addr[9:0]];
        end
    end
    // Disabled RAM output is garbage so misuse of stale data is visible.
    assign ram_rdata = ram_q_vld ? ram_q : 32'hBAD0_BAD0;

    dmem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .ram_ena   (ram_ena),
        .ram_wena  (ram_wena),
        .ram_rena  (ram_rena),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Starts at a negedge with busy=0, returns at the negedge where done is
    // high with req still asserted (caller presents the next request or idles).
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic chk, input logic e_err, input int lat,
                         input logic [31:0] e_rd);
        int guard;
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        acc_q.push_back(cyc);
        exp_q.push_back({chk, e_err, 4'(lat), e_rd});
        @(negedge clk);
        guard = 0;
        while (!done && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: no done within 16 cycles for addr %h", a);
        end
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [37:0] m_e;
    int          m_a;
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
            end else begin
                m_e = exp_q.pop_front();
                m_a = acc_q.pop_front();
                check("err", {31'd0, err}, {31'd0, m_e[36]});
                check("latency", 32'(cyc + 1 - m_a), {28'd0, m_e[35:32]});
                check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
                if (m_e[37]) check("rdata", rdata, m_e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    int ena_snap, wr_snap;
    initial begin
        rst = 1'b1; mem_clr = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00;
        sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        check("rst_done",    {31'd0, done},    32'd0);
        check("rst_err",     {31'd0, err},     32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_rdata",   rdata,            32'd0);
        check("rst_ram_ena", {31'd0, ram_ena}, 32'd0);
        check("rst_ram_addr", ram_addr,        32'd0);
        rst = 1'b0;
        @(negedge clk);

        // word store then loads of every lane/extension
        issue(1, SW, 0, BASE + 8,  32'hDEADBEEF, 0, 0, 2, 32'h0);
        check("sw_mem", mem[2], 32'hDEADBEEF);
        check("sw_ram_addr", last_waddr, 32'd2);
        issue(0, SW, 0, BASE + 8,  32'h0, 1, 0, 3, 32'hDEADBEEF);
        issue(0, SB, 1, BASE + 11, 32'h0, 1, 0, 3, 32'hFFFFFFDE);
        issue(0, SB, 0, BASE + 8,  32'h0, 1, 0, 3, 32'h000000EF);
        issue(0, SB, 1, BASE + 9,  32'h0, 1, 0, 3, 32'hFFFFFFBE);
        issue(0, SH, 1, BASE + 10, 32'h0, 1, 0, 3, 32'hFFFFDEAD);
        issue(0, SH, 0, BASE + 10, 32'h0, 1, 0, 3, 32'h0000DEAD);
        issue(0, SH, 1, BASE + 8,  32'h0, 1, 0, 3, 32'hFFFFBEEF);
        issue(0, SW, 1, BASE + 8,  32'h0, 1, 0, 3, 32'hDEADBEEF);

        // partial stores (read-modify-write)
        issue(1, SB, 0, BASE + 9,  32'h00000055, 0, 0, 4, 32'h0);
        check("sb_mem", mem[2], 32'hDEAD55EF);
        issue(0, SW, 0, BASE + 8,  32'h0, 1, 0, 3, 32'hDEAD55EF);
        issue(1, SH, 0, BASE + 10, 32'h00001234, 0, 0, 4, 32'h0);
        issue(0, SW, 0, BASE + 8,  32'h0, 1, 0, 3, 32'h123455EF);

        // rejected accesses: no RAM activity
        ena_snap = ena_cnt;
        issue(0, SW, 0, BASE + 2,    32'h0, 0, 1, 1, 32'h0);
        issue(1, SH, 0, BASE + 1,    32'hFFFF, 0, 1, 1, 32'h0);
        issue(1, SX, 0, BASE + 0,    32'hFFFF_FFFF, 0, 1, 1, 32'h0);
        issue(0, SW, 0, BASE + 4096, 32'h0, 0, 1, 1, 32'h0);
        issue(1, SW, 0, BASE - 4,    32'h1111_1111, 0, 1, 1, 32'h0);
        issue(1, SB, 0, BASE + 4096, 32'h22, 0, 1, 1, 32'h0);
        idle(2);
        check("err_no_ram_ena", 32'(ena_cnt), 32'(ena_snap));
        check("err_mem2_kept", mem[2], 32'h123455EF);
        check("err_mem0_kept", mem[0], 32'h0);

        // top word of the window, then back-to-back sw -> lb with req held
        issue(1, SW, 0, BASE + 4092, 32'hA5A5_5A5A, 0, 0, 2, 32'h0);
        check("top_ram_addr", last_waddr, 32'd1023);
        issue(0, SW, 0, BASE + 4092, 32'h0, 1, 0, 3, 32'hA5A5_5A5A);
        issue(1, SW, 0, BASE + 12,   32'h80FF_0102, 0, 0, 2, 32'h0);
        issue(0, SB, 1, BASE + 15,   32'h0, 1, 0, 3, 32'hFFFFFF80);
        idle(2);

        // req toggled while busy is ignored
        we = 1'b0; size = SW; sign_ext = 1'b0; addr = BASE + 12; req = 1'b1;
        @(posedge clk); #1;
        acc_q.push_back(cyc);
        exp_q.push_back({1'b1, 1'b0, 4'd3, 32'h80FF_0102});
        @(negedge clk);
        for (int i = 0; i < 10 && !done; i++) begin
            req = ~req; we = 1'b1; size = SB; addr = BASE; wdata = 32'hFF;
            @(negedge clk);
        end
        idle(4);
        check("toggle_mem0_kept", mem[0], 32'h0);
        check("toggle_queue_empty", 32'(exp_q.size()), 32'd0);

        // reset during CAP of a byte store aborts the write-back
        wr_snap = wr_cnt;
        we = 1'b1; size = SB; sign_ext = 1'b0; addr = BASE + 9; wdata = 32'h77; req = 1'b1;
        @(posedge clk);          // accepted -> ACC
        @(negedge clk);          // ACC
        @(negedge clk);          // CAP
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check("abort_done",  {31'd0, done}, 32'd0);
        check("abort_busy",  {31'd0, busy}, 32'd0);
        check("abort_rdata", rdata,         32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_write", 32'(wr_cnt), 32'(wr_snap));
        check("abort_mem2_kept", mem[2], 32'h123455EF);
        issue(0, SW, 0, BASE + 8, 32'h0, 1, 0, 3, 32'h123455EF);
        idle(3);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Sequencer between the CPU load/store stage and the word-organised data RAM (1-cycle registered read; ena/wena/rena controls; word-indexed addr).
- Converts byte addresses to word indices.
- Performs byte/halfword loads with lane extraction and sign/zero extension.
- Performs byte/halfword stores as read-modify-write.
- Flags misaligned, out-of-range and illegal-size accesses without touching the RAM.
- Req/done handshake; the CPU stalls while busy=1.

Parameters:
BASE_ADDR, 32'h1001_0000, byte address mapped to RAM word 0
DEPTH, 1024, RAM depth in words; valid byte range is BASE_ADDR .. BASE_ADDR+4*DEPTH-1

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
req  in  1  access request, sampled only when busy=0
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 illegal
sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
addr  in  32  byte address
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
busy  out  1  high from acceptance until the cycle done is high
done  out  1  one-cycle completion pulse (registered)
err  out  1  valid with done; 1 = access rejected
rdata  out  32  load result, valid with done; holds until next done
ram_ena  out  1  to RAM ena
ram_wena  out  1  to RAM wena
ram_rena  out  1  to RAM rena
ram_addr  out  32  word index = (addr-BASE_ADDR)>>2, upper bits zero
ram_wdata  out  32  to RAM data_in
ram_rdata  in  32  from RAM data_out

Behaviour:
- Reset (synchronous, active-high): state=IDLE; done=0, err=0, rdata=0; latched request regs cleared.
  - ram_ena/ram_wena/ram_rena=0, because RAM controls decode combinationally from state.
  - Reset mid-operation aborts; a pending RMW write is never issued.
- States: IDLE, ACC, CAP, WR, RPT.
- IDLE: busy=0, RAM controls 0. On req=1 at edge k, latch we/size/sign_ext/addr/wdata and check the access.
  - Error if size=11, or size=01 with addr[0]!=0, or size=10 with addr[1:0]!=0, or addr outside range. Range uses 33-bit unsigned subtraction; no wraparound.
  - Error path: -> RPT.
  - Otherwise -> ACC.
- RPT (error path): done=1, err=1 at edge k+1; no RAM access; -> IDLE.
- ACC:
  - Word store: ram_ena=1, ram_wena=1, ram_wdata=wdata; at edge k+2 done=1, err=0; -> IDLE. Latency 2.
  - Load or partial store: ram_ena=1, ram_rena=1; -> CAP.
- CAP: ram_ena=0. ram_rdata is valid only in this state; it is ignored elsewhere because the RAM drives z when disabled.
  - Load: extract lane, extend, and at edge k+3 register rdata, done=1; -> IDLE. Latency 3.
  - Partial store: register merged word (replace byte/half lane selected by addr[1:0], little-endian: offset 0 = [7:0]); -> WR.
- WR: ram_ena=1, ram_wena=1, ram_wdata=merged; at edge k+4 done=1; -> IDLE. Latency 4.
- Loads: word = raw; byte = lane addr[1:0]; half = lane addr[1]; extended per sign_ext. sign_ext is ignored for word loads.
- done is high for exactly one cycle; busy=0 in that same cycle, so the next req may be accepted on that cycle's edge (back-to-back).
- req while busy=1 is ignored, not queued. The CPU must hold req until done.
- ram_addr is driven from the latched address whenever state!=IDLE; otherwise 0.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - default BASE_ADDR/DEPTH constants
- Sub-module dmem_lane (combinational): extract(word, offset, size, sign_ext) and merge(word, wdata, offset, size). It is shared by CAP logic and is unit-testable alone.

Test Plan:
- sw addr=BASE+8 wdata=32'hDEADBEEF -> ram_wena pulse in ACC with ram_addr=2; done at k+2, err=0; then lw BASE+8 -> rdata=32'hDEADBEEF at k+3.
- After sw above: lb BASE+11 sign_ext=1 -> rdata=32'hFFFFFFDE; lbu BASE+8 -> 32'h000000EF; lh BASE+10 -> 32'hFFFFDEAD; lhu -> 32'h0000DEAD.
- sb BASE+9 wdata=32'h00000055 -> read in ACC, write in WR of 32'hDEAD55EF, done at k+4; sh BASE+10 wdata=32'h1234 -> word 32'h123455EF.
- lw BASE+2, sh BASE+1, size=11, and addr=BASE+4096 -> done+err at k+1; ram_ena never asserted; RAM contents unchanged.
- Back-to-back: req held high across sw then lb -> second accepted on the done cycle; req toggled while busy is ignored (exactly one done per accepted req).
- rst asserted during CAP of an sb -> next cycle IDLE, done=0, rdata=0, no ram_wena pulse; target word unchanged.
